// File: rtl/kianv_mem_arbiter.sv
// N-port arbiter that merges kianv native memory masters onto one shared memory port.
// Optional bus watchdog enabled by defining KIANV_ARB_TIMEOUT_EN.
module kianv_mem_arbiter #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned PRIO_MODE      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned SW = DATA_WIDTH / 8,
  localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS-1:0]            s_mem_valid,
  output logic [NUM_PORTS-1:0]            s_mem_ready,
  input  logic [NUM_PORTS*SW-1:0]         s_mem_wstrb,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_mem_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_mem_wdata,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] s_mem_rdata,
  output logic                            mem_valid,
  input  logic                            mem_ready,
  output logic [SW-1:0]                   mem_wstrb,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic [GW-1:0]                   grant_id,
  output logic                            bus_err
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [GW-1:0] winner, lo_any, lo_rr;
  logic          found_rr;
  logic          expire;
  logic          done;

`ifdef KIANV_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q;

  assign expire  = (state_q == StBusy) && !mem_ready && (wd_q == WdW'(TIMEOUT_CYCLES - 1));
  assign bus_err = expire;

  // Holding at zero while idle gives a cleared count on every BUSY entry.
  always_ff @(posedge clk) begin
    if (!resetn || (state_q == StIdle)) begin
      wd_q <= '0;
    end else if (!mem_ready) begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign expire         = 1'b0;
  assign bus_err        = 1'b0;
`endif

  assign done      = (state_q == StBusy) && (mem_ready || expire);
  assign mem_valid = (state_q == StBusy);
  assign grant_id  = grant_q;

  // lo_rr: lowest requester at or above rr_q; lo_any: lowest requester overall (wrap case).
  always_comb begin
    lo_any   = '0;
    lo_rr    = '0;
    found_rr = 1'b0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (s_mem_valid[i]) begin
        lo_any = GW'(i);
        if (i >= int'(rr_q)) begin
          lo_rr    = GW'(i);
          found_rr = 1'b1;
        end
      end
    end
    if (PRIO_MODE != 0) begin
      winner = lo_any;
    end else begin
      winner = found_rr ? lo_rr : lo_any;
    end
  end

  always_comb begin
    mem_addr  = s_mem_addr[ADDR_WIDTH-1:0];
    mem_wdata = s_mem_wdata[DATA_WIDTH-1:0];
    mem_wstrb = s_mem_wstrb[SW-1:0];
    for (int i = 1; i < NUM_PORTS; i++) begin
      if (grant_q == GW'(i)) begin
        mem_addr  = s_mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata = s_mem_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        mem_wstrb = s_mem_wstrb[i*SW +: SW];
      end
    end
  end

  always_comb begin
    s_mem_ready = '0;
    s_mem_rdata = {NUM_PORTS{mem_rdata}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (done && (grant_q == GW'(i))) begin
        s_mem_ready[i] = 1'b1;
        if (expire) begin
          s_mem_rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      StIdle: begin
        if (|s_mem_valid) begin
          grant_d = winner;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (done) begin
          state_d = StIdle;
          rr_d    = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_kianv_mem_arbiter.sv
// Directed bench for kianv_mem_arbiter: a 2-port round-robin instance and a 4-port fixed-priority one.
module tb_kianv_mem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Round-robin, 2 ports
  logic [1:0]  r_valid, r_ready;
  logic [7:0]  r_wstrb;
  logic [63:0] r_addr, r_wdata, r_rdata;
  logic        r_mem_valid, r_mem_ready, r_grant, r_bus_err;
  logic [3:0]  r_mem_wstrb;
  logic [31:0] r_mem_addr, r_mem_wdata, r_mem_rdata;

  // Fixed priority, 4 ports
  logic [3:0]   p_valid, p_ready;
  logic [15:0]  p_wstrb;
  logic [127:0] p_addr, p_wdata, p_rdata;
  logic         p_mem_valid, p_mem_ready, p_bus_err;
  logic [1:0]   p_grant;
  logic [3:0]   p_mem_wstrb;
  logic [31:0]  p_mem_addr, p_mem_wdata, p_mem_rdata;

  kianv_mem_arbiter #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIO_MODE(0), .TIMEOUT_CYCLES(8)
  ) u_rr (
    .clk(clk), .resetn(resetn),
    .s_mem_valid(r_valid), .s_mem_ready(r_ready), .s_mem_wstrb(r_wstrb),
    .s_mem_addr(r_addr), .s_mem_wdata(r_wdata), .s_mem_rdata(r_rdata),
    .mem_valid(r_mem_valid), .mem_ready(r_mem_ready), .mem_wstrb(r_mem_wstrb),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_rdata(r_mem_rdata),
    .grant_id(r_grant), .bus_err(r_bus_err)
  );

  kianv_mem_arbiter #(
    .NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIO_MODE(1), .TIMEOUT_CYCLES(8)
  ) u_pr (
    .clk(clk), .resetn(resetn),
    .s_mem_valid(p_valid), .s_mem_ready(p_ready), .s_mem_wstrb(p_wstrb),
    .s_mem_addr(p_addr), .s_mem_wdata(p_wdata), .s_mem_rdata(p_rdata),
    .mem_valid(p_mem_valid), .mem_ready(p_mem_ready), .mem_wstrb(p_mem_wstrb),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata),
    .grant_id(p_grant), .bus_err(p_bus_err)
  );

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_vec++; if (r_mem_valid !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid got %0b want 0", r_mem_valid); end
    n_vec++; if (r_ready !== 2'b00) begin n_err++; $display("FAIL rst_ready got %b want 00", r_ready); end
    n_vec++; if (r_grant !== 1'b0) begin n_err++; $display("FAIL rst_grant got %0d want 0", r_grant); end
    n_vec++; if (r_bus_err !== 1'b0) begin n_err++; $display("FAIL rst_bus_err got %0b want 0", r_bus_err); end
    n_vec++; if (p_mem_valid !== 1'b0 || p_grant !== 2'd0) begin
      n_err++; $display("FAIL rst_prio got valid=%0b grant=%0d want 0/0", p_mem_valid, p_grant); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    r_valid = 2'b01; r_addr[31:0] = 32'h100; r_wstrb[3:0] = 4'h0;
    #1;
    n_vec++; if (r_mem_valid !== 1'b0) begin n_err++; $display("FAIL rd_idle_valid got %0b want 0", r_mem_valid); end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); #1;
      n_vec++; if (r_mem_valid !== 1'b1 || r_ready !== 2'b00 || r_mem_addr !== 32'h100) begin
        n_err++; $display("FAIL rd_wait%0d got valid=%0b ready=%b addr=%h want 1/00/100",
                          c, r_mem_valid, r_ready, r_mem_addr); end
    end
    @(negedge clk);
    r_mem_ready = 1'b1; r_mem_rdata = 32'hDEADBEEF;
    #1;
    n_vec++; if (r_ready !== 2'b01) begin n_err++; $display("FAIL rd_ready got %b want 01", r_ready); end
    n_vec++; if (r_rdata[31:0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data got %h want deadbeef", r_rdata[31:0]); end
    n_vec++; if (r_grant !== 1'b0) begin n_err++; $display("FAIL rd_grant got %0d want 0", r_grant); end
    @(negedge clk);
    r_valid = 2'b00; r_mem_ready = 1'b0;
    #1;
    n_vec++; if (r_ready !== 2'b00 || r_mem_valid !== 1'b0) begin
      n_err++; $display("FAIL rd_after got ready=%b valid=%0b want 00/0", r_ready, r_mem_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    apply_reset();
    r_valid = 2'b11; r_addr = {32'hB0, 32'hA0}; r_mem_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); #1;
      n_vec++; if (r_mem_valid !== 1'b1 || r_grant !== 1'(t % 2)) begin
        n_err++; $display("FAIL b2b_grant%0d got valid=%0b grant=%0d want 1/%0d", t, r_mem_valid, r_grant, t % 2); end
      exp_addr = (t % 2 == 0) ? 32'hA0 : 32'hB0;
      n_vec++; if (r_mem_addr !== exp_addr) begin
        n_err++; $display("FAIL b2b_addr%0d got %h want %h", t, r_mem_addr, exp_addr); end
      n_vec++; if (r_ready !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL b2b_ready%0d got %b want one-hot port %0d", t, r_ready, t % 2); end
      @(negedge clk); #1;
      n_vec++; if (r_mem_valid !== 1'b0 || r_ready !== 2'b00) begin
        n_err++; $display("FAIL b2b_gap%0d got valid=%0b ready=%b want 0/00", t, r_mem_valid, r_ready); end
    end
    r_valid = 2'b00; r_mem_ready = 1'b0;
  endtask

  task automatic test_fixed_prio();
    @(negedge clk);
    p_valid = 4'b1010;
    p_addr[63:32] = 32'h1000; p_wstrb[7:4] = 4'h0;
    p_addr[127:96] = 32'h3000; p_wdata[127:96] = 32'hA5A5A5A5; p_wstrb[15:12] = 4'hF;
    @(negedge clk); #1;
    n_vec++; if (p_mem_valid !== 1'b1 || p_grant !== 2'd1 || p_mem_wstrb !== 4'h0) begin
      n_err++; $display("FAIL prio_first got valid=%0b grant=%0d wstrb=%h want 1/1/0", p_mem_valid, p_grant, p_mem_wstrb); end
    @(negedge clk);
    p_mem_ready = 1'b1;
    #1;
    n_vec++; if (p_ready !== 4'b0010) begin n_err++; $display("FAIL prio_ready1 got %b want 0010", p_ready); end
    @(negedge clk);
    p_mem_ready = 1'b0; p_valid = 4'b1000;
    #1;
    n_vec++; if (p_mem_valid !== 1'b0) begin n_err++; $display("FAIL prio_gap got %0b want 0", p_mem_valid); end
    @(negedge clk);
    p_mem_ready = 1'b1;
    #1;
    n_vec++; if (p_grant !== 2'd3 || p_mem_wstrb !== 4'hF || p_mem_addr !== 32'h3000 || p_mem_wdata !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL prio_second got grant=%0d wstrb=%h addr=%h wdata=%h want 3/f/3000/a5a5a5a5",
                        p_grant, p_mem_wstrb, p_mem_addr, p_mem_wdata); end
    n_vec++; if (p_ready !== 4'b1000) begin n_err++; $display("FAIL prio_ready3 got %b want 1000", p_ready); end
    @(negedge clk);
    p_mem_ready = 1'b0; p_valid = 4'b0000;
  endtask

  task automatic test_write_drop();
    apply_reset();
    r_valid = 2'b10;
    r_addr  = {32'h2000, 32'h0};
    r_wdata = {32'h12345678, 32'h0};
    r_wstrb = {4'h3, 4'h0};
    @(negedge clk); #1;
    n_vec++; if (r_mem_valid !== 1'b1 || r_grant !== 1'b1 || r_mem_addr !== 32'h2000
                 || r_mem_wdata !== 32'h12345678 || r_mem_wstrb !== 4'h3) begin
      n_err++; $display("FAIL wr_busy got valid=%0b grant=%0d addr=%h wdata=%h wstrb=%h want 1/1/2000/12345678/3",
                        r_mem_valid, r_grant, r_mem_addr, r_mem_wdata, r_mem_wstrb); end
    @(negedge clk);
    r_valid = 2'b00;
    #1;
    n_vec++; if (r_mem_valid !== 1'b1 || r_mem_addr !== 32'h2000 || r_mem_wdata !== 32'h12345678
                 || r_mem_wstrb !== 4'h3 || r_ready !== 2'b00) begin
      n_err++; $display("FAIL wr_drop got valid=%0b addr=%h wdata=%h wstrb=%h ready=%b want 1/2000/12345678/3/00",
                        r_mem_valid, r_mem_addr, r_mem_wdata, r_mem_wstrb, r_ready); end
    @(negedge clk);
    r_mem_ready = 1'b1;
    #1;
    n_vec++; if (r_ready !== 2'b10) begin n_err++; $display("FAIL wr_ready got %b want 10", r_ready); end
    @(negedge clk);
    r_mem_ready = 1'b0;
    #1;
    n_vec++; if (r_mem_valid !== 1'b0) begin n_err++; $display("FAIL wr_idle got %0b want 0", r_mem_valid); end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    r_valid = 2'b10; r_addr[63:32] = 32'h300;
    @(negedge clk); #1;
    n_vec++; if (r_mem_valid !== 1'b1 || r_grant !== 1'b1) begin
      n_err++; $display("FAIL rb_busy got valid=%0b grant=%0d want 1/1", r_mem_valid, r_grant); end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1; r_mem_ready = 1'b1;
    #1;
    n_vec++; if (r_mem_valid !== 1'b0 || r_grant !== 1'b0 || r_ready !== 2'b00) begin
      n_err++; $display("FAIL rb_abort got valid=%0b grant=%0d ready=%b want 0/0/00", r_mem_valid, r_grant, r_ready); end
    @(negedge clk); #1;
    n_vec++; if (r_mem_valid !== 1'b1 || r_grant !== 1'b1 || r_ready !== 2'b10) begin
      n_err++; $display("FAIL rb_regrant got valid=%0b grant=%0d ready=%b want 1/1/10", r_mem_valid, r_grant, r_ready); end
    @(negedge clk);
    r_valid = 2'b00; r_mem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    r_valid = 2'b11; r_addr = {32'h44, 32'h40}; r_mem_ready = 1'b0; r_mem_rdata = 32'hCAFEF00D;
`ifdef KIANV_ARB_TIMEOUT_EN
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk); #1;
      n_vec++; if (r_bus_err !== 1'b0 || r_ready !== 2'b00 || r_mem_valid !== 1'b1) begin
        n_err++; $display("FAIL to_wait%0d got err=%0b ready=%b valid=%0b want 0/00/1", c, r_bus_err, r_ready, r_mem_valid); end
    end
    @(negedge clk); #1;
    n_vec++; if (r_bus_err !== 1'b1 || r_ready !== 2'b01) begin
      n_err++; $display("FAIL to_expire got err=%0b ready=%b want 1/01", r_bus_err, r_ready); end
    n_vec++; if (r_rdata !== {32'hCAFEF00D, 32'h0}) begin
      n_err++; $display("FAIL to_rdata got %h want cafef00d00000000", r_rdata); end
    @(negedge clk);
    r_valid = 2'b10;
    #1;
    n_vec++; if (r_bus_err !== 1'b0 || r_mem_valid !== 1'b0) begin
      n_err++; $display("FAIL to_idle got err=%0b valid=%0b want 0/0", r_bus_err, r_mem_valid); end
`else
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); #1;
      n_vec++; if (r_bus_err !== 1'b0 || r_ready !== 2'b00 || r_mem_valid !== 1'b1) begin
        n_err++; $display("FAIL nto_wait%0d got err=%0b ready=%b valid=%0b want 0/00/1", c, r_bus_err, r_ready, r_mem_valid); end
    end
    @(negedge clk);
    r_mem_ready = 1'b1;
    #1;
    n_vec++; if (r_ready !== 2'b01) begin n_err++; $display("FAIL nto_ready got %b want 01", r_ready); end
    @(negedge clk);
    r_mem_ready = 1'b0; r_valid = 2'b10;
`endif
    @(negedge clk);
    r_mem_ready = 1'b1;
    #1;
    n_vec++; if (r_grant !== 1'b1 || r_mem_addr !== 32'h44 || r_ready !== 2'b10) begin
      n_err++; $display("FAIL to_next got grant=%0d addr=%h ready=%b want 1/44/10", r_grant, r_mem_addr, r_ready); end
    @(negedge clk);
    r_valid = 2'b00; r_mem_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    r_valid = '0; r_wstrb = '0; r_addr = '0; r_wdata = '0; r_mem_ready = 1'b0; r_mem_rdata = '0;
    p_valid = '0; p_wstrb = '0; p_addr = '0; p_wdata = '0; p_mem_ready = 1'b0; p_mem_rdata = 32'h0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_fixed_prio();
    test_write_drop();
    test_reset_busy();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got still running want finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
